// File: rtl/router_pkg.sv
// Shared definitions for the 3x3 mesh router: flit layout, mesh size,
// port/direction encoding and node-id coordinate helpers.
package router_pkg;

  localparam int MESH_DIM  = 3;
  localparam int FLIT_W    = 64;
  localparam int DATA_W    = 32;
  localparam int ID_W      = 16;
  localparam int NUM_PORTS = 5;

  localparam int VALID_BIT = 63;
  localparam int SRC_MSB   = 62;
  localparam int SRC_LSB   = 48;
  localparam int DST_MSB   = 47;
  localparam int DST_LSB   = 32;
  localparam int PAY_MSB   = 31;
  localparam int PAY_LSB   = 0;

  // Encoding doubles as the input/output port index and the arbitration priority order.
  typedef enum logic [2:0] {
    DIR_LEFT  = 3'd0,
    DIR_RIGHT = 3'd1,
    DIR_UP    = 3'd2,
    DIR_DOWN  = 3'd3,
    DIR_LOCAL = 3'd4
  } dir_e;

  function automatic logic [ID_W-1:0] id_to_x(input logic [ID_W-1:0] id);
    return (id - ID_W'(1)) % ID_W'(MESH_DIM);
  endfunction

  function automatic logic [ID_W-1:0] id_to_y(input logic [ID_W-1:0] id);
    return (id - ID_W'(1)) / ID_W'(MESH_DIM);
  endfunction

  function automatic logic id_valid(input logic [ID_W-1:0] id);
    return (id != '0) && (id <= ID_W'(MESH_DIM * MESH_DIM));
  endfunction

endpackage

// File: rtl/router_route_calc.sv
// Combinational XY route selection for one flit: X is resolved before Y,
// and a valid flit with an out-of-range destination is flagged invalid.
module router_route_calc
  import router_pkg::*;
(
  input  logic [ID_W-1:0]   own_id,
  input  logic [FLIT_W-1:0] flit,
  output logic              req,
  output logic              invalid,
  output dir_e              dir
);

  logic [ID_W-1:0] dst;
  logic [ID_W-1:0] own_x;
  logic [ID_W-1:0] own_y;
  logic [ID_W-1:0] dst_x;
  logic [ID_W-1:0] dst_y;

  always_comb begin
    dst     = flit[DST_MSB:DST_LSB];
    own_x   = id_to_x(own_id);
    own_y   = id_to_y(own_id);
    dst_x   = id_to_x(dst);
    dst_y   = id_to_y(dst);
    req     = flit[VALID_BIT] && id_valid(dst);
    invalid = flit[VALID_BIT] && !id_valid(dst);
    dir     = DIR_LOCAL;
    if (dst_x < own_x)      dir = DIR_LEFT;
    else if (dst_x > own_x) dir = DIR_RIGHT;
    else if (dst_y < own_y) dir = DIR_UP;
    else if (dst_y > own_y) dir = DIR_DOWN;
  end

endmodule

// File: rtl/router.sv
// Five-port XY mesh router: one registered hop per cycle, fixed-priority
// arbitration per output, a one-entry local injection slot and CPU ejection.
module router
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] in_left,
  input  logic [FLIT_W-1:0] in_right,
  input  logic [FLIT_W-1:0] in_up,
  input  logic [FLIT_W-1:0] in_down,
  input  logic [DATA_W-1:0] from_cpu,
  input  logic [ID_W-1:0]   router_id,
  input  logic [ID_W-1:0]   dest_id,
  output logic [FLIT_W-1:0] out_left,
  output logic [FLIT_W-1:0] out_right,
  output logic [FLIT_W-1:0] out_up,
  output logic [FLIT_W-1:0] out_down,
  output logic [DATA_W-1:0] to_cpu,
  input  logic              set_fi,
  output logic              to_cpu_valid,
  output logic [ID_W-1:0]   drop_count
);

  logic [FLIT_W-1:0]    in_flits [NUM_PORTS];
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] bad;
  dir_e                 dir_sel  [NUM_PORTS];

  logic [NUM_PORTS-1:0] busy;
  logic [NUM_PORTS-1:0] grant;
  logic [2:0]           drops;
  logic [ID_W:0]        drop_sum;

  logic [FLIT_W-1:0] out_d [NUM_PORTS];
  logic [FLIT_W-1:0] out_q [NUM_PORTS-1];
  logic [FLIT_W-1:0] pend_d, pend_q;
  logic [DATA_W-1:0] to_cpu_d, to_cpu_q;
  logic              to_cpu_valid_d, to_cpu_valid_q;
  logic [ID_W-1:0]   drop_d, drop_q;

  assign in_flits[DIR_LEFT]  = in_left;
  assign in_flits[DIR_RIGHT] = in_right;
  assign in_flits[DIR_UP]    = in_up;
  assign in_flits[DIR_DOWN]  = in_down;
  assign in_flits[DIR_LOCAL] = pend_q;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_route
    router_route_calc u_route_calc (
      .own_id  (router_id),
      .flit    (in_flits[g]),
      .req     (req[g]),
      .invalid (bad[g]),
      .dir     (dir_sel[g])
    );
  end

  // Inputs are visited in priority order, so the first requester claims each output.
  always_comb begin
    busy  = '0;
    grant = '0;
    drops = '0;
    for (int o = 0; o < NUM_PORTS; o++) out_d[o] = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (req[i] && !busy[dir_sel[i]]) begin
        busy[dir_sel[i]]  = 1'b1;
        grant[i]          = 1'b1;
        out_d[dir_sel[i]] = in_flits[i];
      end
    end
    for (int i = 0; i < NUM_PORTS - 1; i++) begin
      if ((req[i] && !grant[i]) || bad[i]) drops = drops + 3'd1;
    end
    if (bad[DIR_LOCAL]) drops = drops + 3'd1;

    drop_sum = {1'b0, drop_q} + (ID_W + 1)'(drops);
    drop_d   = drop_sum[ID_W] ? '1 : drop_sum[ID_W-1:0];

    to_cpu_valid_d = out_d[DIR_LOCAL][VALID_BIT];
    to_cpu_d       = to_cpu_valid_d ? out_d[DIR_LOCAL][PAY_MSB:PAY_LSB] : to_cpu_q;

    // A losing local flit stays put; only a win or a bad destination frees the slot.
    pend_d = pend_q;
    if (pend_q[VALID_BIT]) begin
      if (grant[DIR_LOCAL] || bad[DIR_LOCAL]) pend_d = '0;
    end else if (set_fi) begin
      pend_d = {1'b1, router_id[14:0], dest_id, from_cpu};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < NUM_PORTS - 1; o++) out_q[o] <= '0;
      pend_q         <= '0;
      to_cpu_q       <= '0;
      to_cpu_valid_q <= 1'b0;
      drop_q         <= '0;
    end else begin
      for (int o = 0; o < NUM_PORTS - 1; o++) out_q[o] <= out_d[o];
      pend_q         <= pend_d;
      to_cpu_q       <= to_cpu_d;
      to_cpu_valid_q <= to_cpu_valid_d;
      drop_q         <= drop_d;
    end
  end

  assign out_left     = out_q[DIR_LEFT];
  assign out_right    = out_q[DIR_RIGHT];
  assign out_up       = out_q[DIR_UP];
  assign out_down     = out_q[DIR_DOWN];
  assign to_cpu       = to_cpu_q;
  assign to_cpu_valid = to_cpu_valid_q;
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_router.sv
// Directed bench for router: hand-computed vectors checked with immediate
// assertions one cycle after each rising edge.
module tb_router;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_left, in_right, in_up, in_down;
  logic [31:0] from_cpu;
  logic [15:0] router_id, dest_id;
  logic [63:0] out_left, out_right, out_up, out_down;
  logic [31:0] to_cpu;
  logic        set_fi;
  logic        to_cpu_valid;
  logic [15:0] drop_count;

  int tests    = 0;
  int failures = 0;

  logic [63:0] f_a, f_b, f_c;

  always #5 clk = ~clk;

  router dut (
    .clk          (clk),
    .rst          (rst),
    .in_left      (in_left),
    .in_right     (in_right),
    .in_up        (in_up),
    .in_down      (in_down),
    .from_cpu     (from_cpu),
    .router_id    (router_id),
    .dest_id      (dest_id),
    .out_left     (out_left),
    .out_right    (out_right),
    .out_up       (out_up),
    .out_down     (out_down),
    .to_cpu       (to_cpu),
    .set_fi       (set_fi),
    .to_cpu_valid (to_cpu_valid),
    .drop_count   (drop_count)
  );

  function automatic logic [63:0] mk_flit(input logic [14:0] src, input logic [15:0] dst,
                                          input logic [31:0] pay);
    return {1'b1, src, dst, pay};
  endfunction

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic clearInputs();
    in_left  = '0;
    in_right = '0;
    in_up    = '0;
    in_down  = '0;
    set_fi   = 1'b0;
  endtask

  initial begin
    // Reset with every input active.
    rst       = 1'b1;
    router_id = 16'd5;
    dest_id   = 16'd6;
    from_cpu  = 32'h1111_2222;
    set_fi    = 1'b1;
    in_left   = mk_flit(15'd4, 16'd6, 32'hAAAA_0001);
    in_right  = mk_flit(15'd6, 16'd5, 32'hAAAA_0002);
    in_up     = mk_flit(15'd2, 16'd8, 32'hAAAA_0003);
    in_down   = mk_flit(15'd8, 16'd2, 32'hAAAA_0004);
    applyStimulus();
    checkOutput("rst_out_left", out_left, 64'h0);
    checkOutput("rst_out_right", out_right, 64'h0);
    checkOutput("rst_out_up", out_up, 64'h0);
    checkOutput("rst_out_down", out_down, 64'h0);
    checkOutput("rst_to_cpu", 64'(to_cpu), 64'h0);
    checkOutput("rst_to_cpu_valid", 64'(to_cpu_valid), 64'h0);
    checkOutput("rst_drop_count", 64'(drop_count), 64'h0);
    clearInputs();
    applyStimulus();
    rst = 1'b0;

    // Transit left -> right at node 5.
    f_a = mk_flit(15'd4, 16'd6, 32'hDEADBEEF);
    in_left = f_a;
    applyStimulus();
    checkOutput("transit_out_right", out_right, f_a);
    checkOutput("transit_out_left", out_left, 64'h0);
    checkOutput("transit_out_up", out_up, 64'h0);
    checkOutput("transit_out_down", out_down, 64'h0);
    in_left = '0;
    applyStimulus();
    checkOutput("transit_one_cycle", out_right, 64'h0);

    // Eject from right, route up-input flit down to node 8, same cycle.
    f_a = mk_flit(15'd6, 16'd5, 32'hCAFE0001);
    f_b = mk_flit(15'd2, 16'd8, 32'h0000_0008);
    in_right = f_a;
    in_up    = f_b;
    applyStimulus();
    checkOutput("eject_to_cpu", 64'(to_cpu), 64'hCAFE0001);
    checkOutput("eject_valid", 64'(to_cpu_valid), 64'h1);
    checkOutput("ydown_out_down", out_down, f_b);
    clearInputs();
    applyStimulus();
    checkOutput("eject_valid_pulse", 64'(to_cpu_valid), 64'h0);
    checkOutput("eject_to_cpu_hold", 64'(to_cpu), 64'hCAFE0001);
    checkOutput("ydown_one_cycle", out_down, 64'h0);

    // Injection at node 1 toward node 9.
    router_id = 16'd1;
    dest_id   = 16'd9;
    from_cpu  = 32'h12345678;
    set_fi    = 1'b1;
    applyStimulus();
    checkOutput("inj_capture_cycle", out_right, 64'h0);
    set_fi = 1'b0;
    applyStimulus();
    checkOutput("inj_out_right", out_right, 64'h8001_0009_12345678);
    applyStimulus();
    checkOutput("inj_one_cycle", out_right, 64'h0);

    // Contention at node 5 for the right output: left wins, up dropped, local waits.
    router_id = 16'd5;
    dest_id   = 16'd6;
    from_cpu  = 32'h0BAD_F00D;
    set_fi    = 1'b1;
    applyStimulus();
    set_fi  = 1'b0;
    f_a     = mk_flit(15'd4, 16'd6, 32'h1111_0004);
    f_b     = mk_flit(15'd2, 16'd6, 32'h2222_0002);
    in_left = f_a;
    in_up   = f_b;
    applyStimulus();
    checkOutput("cont_out_right", out_right, f_a);
    checkOutput("cont_out_down", out_down, 64'h0);
    checkOutput("cont_drop_count", 64'(drop_count), 64'd1);
    clearInputs();
    applyStimulus();
    checkOutput("cont_local_next", out_right, 64'h8005_0006_0BADF00D);
    checkOutput("cont_drop_stable", 64'(drop_count), 64'd1);

    // Invalid destinations 0 and 10.
    in_left = mk_flit(15'd4, 16'd0, 32'h0000_0000);
    applyStimulus();
    checkOutput("inv0_out_right", out_right, 64'h0);
    checkOutput("inv0_out_left", out_left, 64'h0);
    checkOutput("inv0_drop_count", 64'(drop_count), 64'd2);
    in_left = mk_flit(15'd4, 16'd10, 32'h0000_000A);
    applyStimulus();
    checkOutput("inv10_out_right", out_right, 64'h0);
    checkOutput("inv10_out_down", out_down, 64'h0);
    checkOutput("inv10_valid", 64'(to_cpu_valid), 64'h0);
    checkOutput("inv10_drop_count", 64'(drop_count), 64'd3);

    // A flit with the valid bit clear is ignored.
    in_left = 64'h0004_0006_5555_5555;
    applyStimulus();
    checkOutput("novalid_out_right", out_right, 64'h0);
    checkOutput("novalid_drop_count", 64'(drop_count), 64'd3);
    in_left = '0;

    // Corner nodes: node 9 routes dest 3 up; node 1 ejects dest 1.
    router_id = 16'd9;
    f_c   = mk_flit(15'd6, 16'd3, 32'h0303_0303);
    in_up = f_c;
    applyStimulus();
    checkOutput("corner9_out_up", out_up, f_c);
    checkOutput("corner9_out_right", out_right, 64'h0);
    in_up     = '0;
    router_id = 16'd1;
    in_down   = mk_flit(15'd4, 16'd1, 32'h0101_0101);
    applyStimulus();
    checkOutput("corner1_to_cpu", 64'(to_cpu), 64'h0101_0101);
    checkOutput("corner1_valid", 64'(to_cpu_valid), 64'h1);
    in_down = '0;

    // Reset while a flit is pending discards it.
    router_id = 16'd5;
    dest_id   = 16'd6;
    from_cpu  = 32'hAAAA_5555;
    set_fi    = 1'b1;
    applyStimulus();
    set_fi = 1'b0;
    rst    = 1'b1;
    applyStimulus();
    checkOutput("midrst_out_right", out_right, 64'h0);
    checkOutput("midrst_drop_count", 64'(drop_count), 64'h0);
    rst = 1'b0;
    applyStimulus();
    checkOutput("midrst_pending_gone", out_right, 64'h0);
    applyStimulus();
    checkOutput("midrst_pending_gone2", out_right, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/router.md
Name: router

Overview:
- Synchronous 5-port mesh router (left, right, up, down, local CPU) for the 3x3 processor network of nine CPU + router tiles.
- Nodes are numbered 1..9, row-major: x=(id-1)%3, y=(id-1)/3. Left is x-1, right is x+1, up is y-1, down is y+1.
- Routing is dimension-ordered XY with one registered hop per cycle.
- Local payloads are packetised toward a programmed destination; flits addressed to this node are ejected to the CPU.

Parameters:
- MESH_DIM, 3, nodes per row/column; valid ids are 1..MESH_DIM*MESH_DIM.
- FLIT_W, 64, flit width.
- DATA_W, 32, payload width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_left, in_right, in_up, in_down  in  64 each  flits from the neighbours.
- from_cpu  in  32  payload to inject.
- router_id  in  16  this node's id.
- dest_id  in  16  destination id for injected payloads.
- out_left, out_right, out_up, out_down  out  64 each  flits to the neighbours.
- to_cpu  out  32  payload of the last ejected flit.
- set_fi  in  1  inject request; from_cpu is sampled when high.
- to_cpu_valid  out  1  one-cycle pulse when to_cpu is updated.
- drop_count  out  16  saturating count of discarded flits.

Behaviour:
- Flit format: [63] valid, [62:48] source id (low 15 bits), [47:32] destination id, [31:0] payload.
- A flit whose bit 63 is 0 is ignored. Idle outputs drive 64'h0.
- Route per valid flit, comparing destination (dx,dy) with own (x,y):
  - dx<x -> left; dx>x -> right.
  - else dy<y -> up; dy>y -> down.
  - else eject to local.
- A destination of 0 or above MESH_DIM^2 is dropped and counted.
- Injection:
  - A one-entry pending register.
  - If set_fi=1 and the register is empty, capture {1, router_id[14:0], dest_id, from_cpu} at the edge.
  - set_fi is ignored while the register is occupied.
  - The pending flit competes for its route starting the cycle after capture; it is cleared when it wins.
  - set_fi held high re-injects from_cpu every time the register frees.
- Arbitration, per output (4 directions + eject), each cycle: fixed priority left > right > up > down > pending local.
  - One winner per output.
  - Losing transit flits are dropped and drop_count increments by the number dropped that cycle.
  - drop_count saturates at 16'hFFFF.
  - A losing local flit is not dropped; it stays pending.
- Latency:
  - A transit flit sampled on in_* at edge N appears on the chosen out_* (bit-exact, unchanged) after edge N, held for exactly one cycle.
  - Injected flits: capture at edge N, earliest output after edge N+1.
- Eject: the winner's payload is registered into to_cpu and to_cpu_valid=1 for one cycle. to_cpu holds its value otherwise. Self-addressed injection (dest_id==router_id) ejects locally.
- Boundary handling: XY routing never selects an off-mesh side for a valid destination. Edge outputs not connected at the network level still drive 64'h0 when idle.
- Reset: all out_* = 0, to_cpu = 0, to_cpu_valid = 0, pending cleared, drop_count = 0. Reset mid-operation discards in-flight and pending flits.

Decomposition:
- Package router_pkg:
  - flit field bit positions and widths.
  - MESH_DIM.
  - direction encoding (LEFT, RIGHT, UP, DOWN, LOCAL).
  - functions id_to_x, id_to_y, id_valid.
- One sub-module router_route_calc: combinational; (own id, flit) -> direction plus invalid flag. Instantiated once per input (5 copies).

Test Plan:
- Reset: rst=1 with all inputs active -> all out_* = 0, to_cpu = 0, to_cpu_valid = 0, drop_count = 0 after one edge.
- Transit: router_id=5, in_left={1,15'd4,16'd6,32'hDEADBEEF} for one cycle -> out_right equals that flit for exactly one cycle; other outputs 0.
- Eject and Y routing: router_id=5, in_right has dest 5 payload 32'hCAFE0001, and in_up has dest 8 in the same cycle -> to_cpu=32'hCAFE0001 with to_cpu_valid=1, and out_down carries the dest-8 flit.
- Injection: router_id=1, dest_id=9, from_cpu=32'h12345678, set_fi pulsed -> out_right={1,15'd1,16'd9,32'h12345678} on the second cycle.
- Contention: router_id=5, in_left and in_up both dest 6, while local pending dest 6 -> out_right carries the left flit; drop_count=1; local flit appears the next cycle.
- Invalid destination: flit with dest 0, then dest 10 -> no output activity; drop_count=2.
